// File: rtl/morse_pkg.sv
// rtl/morse_pkg.sv - character codes, Morse unit constants, FSM state and ROM entry types
package morse_pkg;

  localparam int CODE_SPACE     = 36;
  localparam int CODE_MAX_VALID = 36;

  localparam int DOT        = 1;
  localparam int DASH       = 3;
  localparam int ELEM_GAP   = 1;
  localparam int CHAR_GAP   = 3;
  localparam int WORD_EXTRA = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MARK,
    S_ELEM_GAP,
    S_CHAR_GAP,
    S_WORD_GAP
  } state_t;

  // pattern is left-aligned: pattern[4] is the first element, 1 = dash
  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [4:0] pattern;
  } rom_entry_t;

endpackage

// File: rtl/morse_rom.sv
// rtl/morse_rom.sv - combinational International Morse lookup for A..Z and 0..9
module morse_rom
  import morse_pkg::*;
(
  input  logic [5:0] i_char,
  output rom_entry_t o_entry
);

  always_comb begin
    o_entry = '0;
    case (i_char)
      6'd0:  o_entry = {1'b1, 3'd2, 5'b01000};
      6'd1:  o_entry = {1'b1, 3'd4, 5'b10000};
      6'd2:  o_entry = {1'b1, 3'd4, 5'b10100};
      6'd3:  o_entry = {1'b1, 3'd3, 5'b10000};
      6'd4:  o_entry = {1'b1, 3'd1, 5'b00000};
      6'd5:  o_entry = {1'b1, 3'd4, 5'b00100};
      6'd6:  o_entry = {1'b1, 3'd3, 5'b11000};
      6'd7:  o_entry = {1'b1, 3'd4, 5'b00000};
      6'd8:  o_entry = {1'b1, 3'd2, 5'b00000};
      6'd9:  o_entry = {1'b1, 3'd4, 5'b01110};
      6'd10: o_entry = {1'b1, 3'd3, 5'b10100};
      6'd11: o_entry = {1'b1, 3'd4, 5'b01000};
      6'd12: o_entry = {1'b1, 3'd2, 5'b11000};
      6'd13: o_entry = {1'b1, 3'd2, 5'b10000};
      6'd14: o_entry = {1'b1, 3'd3, 5'b11100};
      6'd15: o_entry = {1'b1, 3'd4, 5'b01100};
      6'd16: o_entry = {1'b1, 3'd4, 5'b11010};
      6'd17: o_entry = {1'b1, 3'd3, 5'b01000};
      6'd18: o_entry = {1'b1, 3'd3, 5'b00000};
      6'd19: o_entry = {1'b1, 3'd1, 5'b10000};
      6'd20: o_entry = {1'b1, 3'd3, 5'b00100};
      6'd21: o_entry = {1'b1, 3'd4, 5'b00010};
      6'd22: o_entry = {1'b1, 3'd3, 5'b01100};
      6'd23: o_entry = {1'b1, 3'd4, 5'b10010};
      6'd24: o_entry = {1'b1, 3'd4, 5'b10110};
      6'd25: o_entry = {1'b1, 3'd4, 5'b11000};
      6'd26: o_entry = {1'b1, 3'd5, 5'b11111};
      6'd27: o_entry = {1'b1, 3'd5, 5'b01111};
      6'd28: o_entry = {1'b1, 3'd5, 5'b00111};
      6'd29: o_entry = {1'b1, 3'd5, 5'b00011};
      6'd30: o_entry = {1'b1, 3'd5, 5'b00001};
      6'd31: o_entry = {1'b1, 3'd5, 5'b00000};
      6'd32: o_entry = {1'b1, 3'd5, 5'b10000};
      6'd33: o_entry = {1'b1, 3'd5, 5'b11000};
      6'd34: o_entry = {1'b1, 3'd5, 5'b11100};
      6'd35: o_entry = {1'b1, 3'd5, 5'b11110};
      default: o_entry = '0;
    endcase
  end

endmodule

// File: rtl/morse_tx.sv
// rtl/morse_tx.sv - Morse keyer: one character per handshake, registered key/busy/err/ready
// Optional sidetone output tone_out enabled by MORSE_TX_SIDETONE_EN.
module morse_tx
  import morse_pkg::*;
#(
  parameter int DOT_CYCLES = 10,
  parameter int TONE_DIV   = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic       key_out,
  output logic       busy,
  output logic       err
`ifdef MORSE_TX_SIDETONE_EN
  ,
  output logic       tone_out
`endif
);

  localparam int CW = $clog2(4 * DOT_CYCLES);
  localparam logic [CW-1:0] N_DOT  = CW'(DOT * DOT_CYCLES - 1);
  localparam logic [CW-1:0] N_DASH = CW'(DASH * DOT_CYCLES - 1);
  localparam logic [CW-1:0] N_ELEM = CW'(ELEM_GAP * DOT_CYCLES - 1);
  localparam logic [CW-1:0] N_CHAR = CW'(CHAR_GAP * DOT_CYCLES - 1);
  // The IDLE/handshake cycle after the word gap completes the 4-unit pause.
  localparam logic [CW-1:0] N_WORD = CW'(WORD_EXTRA * DOT_CYCLES - 2);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [2:0]    r_len;
  logic [4:0]    r_pat;
  logic          r_ready;
  logic          r_key;
  logic          r_busy;
  logic          r_err;

  state_t        w_next;
  logic [CW-1:0] w_cnt_d;
  logic [2:0]    w_idx_d;
  logic [2:0]    w_len_d;
  logic [4:0]    w_pat_d;
  logic          w_err_d;
  logic          w_hs;
  rom_entry_t    w_rom;

  morse_rom u_rom (
    .i_char  (char_in),
    .o_entry (w_rom)
  );

  assign w_hs = char_valid & r_ready;

  always_comb begin
    w_next  = r_state;
    w_cnt_d = r_cnt;
    w_idx_d = r_idx;
    w_len_d = r_len;
    w_pat_d = r_pat;
    w_err_d = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          if (w_rom.valid) begin
            w_next  = S_MARK;
            w_pat_d = w_rom.pattern;
            w_len_d = w_rom.len;
            w_idx_d = 3'd0;
            w_cnt_d = w_rom.pattern[4] ? N_DASH : N_DOT;
          end else if (char_in > 6'(CODE_MAX_VALID)) begin
            w_err_d = 1'b1;
          end else begin
            w_next  = S_WORD_GAP;
            w_cnt_d = N_WORD;
          end
        end
      end
      S_MARK: begin
        if (r_cnt == '0) begin
          if (r_idx == r_len - 3'd1) begin
            w_next  = S_CHAR_GAP;
            w_cnt_d = N_CHAR;
          end else begin
            w_next  = S_ELEM_GAP;
            w_cnt_d = N_ELEM;
            w_idx_d = r_idx + 3'd1;
          end
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      S_ELEM_GAP: begin
        if (r_cnt == '0) begin
          w_next  = S_MARK;
          w_cnt_d = r_pat[3'd4 - r_idx] ? N_DASH : N_DOT;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (r_cnt == '0) begin
          w_next = S_IDLE;
        end else begin
          w_cnt_d = r_cnt - CW'(1);
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_pat   <= '0;
      r_ready <= 1'b0;
      r_key   <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_d;
      r_idx   <= w_idx_d;
      r_len   <= w_len_d;
      r_pat   <= w_pat_d;
      r_ready <= (w_next == S_IDLE);
      r_key   <= (w_next == S_MARK);
      r_busy  <= (w_next != S_IDLE);
      r_err   <= w_err_d;
    end
  end

  assign char_ready = r_ready;
  assign key_out    = r_key;
  assign busy       = r_busy;
  assign err        = r_err;

`ifdef MORSE_TX_SIDETONE_EN
  localparam int TW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [TW-1:0] r_tone_cnt;
  logic          r_tone;
  logic          w_key_d;

  assign w_key_d = (w_next == S_MARK);

  // Restart the divider on each mark so every mark begins with tone low.
  always_ff @(posedge clk) begin
    if (rst || !w_key_d || !r_key) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == TW'(TONE_DIV - 1)) begin
      r_tone_cnt <= '0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + TW'(1);
    end
  end

  assign tone_out = r_tone;
`endif

endmodule

// File: tb/tb_morse_tx.sv
// tb/tb_morse_tx.sv - scoreboard bench for morse_tx: expected key run lengths vs observed
module tb_morse_tx;

  localparam int D = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] char_in = '0;
  logic       char_valid = 1'b0;
  logic       char_ready, key_out, busy, err;
`ifdef MORSE_TX_SIDETONE_EN
  logic       tone_out;
`endif

  always #5 clk = ~clk;

  morse_tx #(.DOT_CYCLES(D), .TONE_DIV(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .key_out    (key_out),
    .busy       (busy),
    .err        (err)
`ifdef MORSE_TX_SIDETONE_EN
    ,
    .tone_out   (tone_out)
`endif
  );

  typedef struct {
    bit lvl;
    int len;
  } run_t;

  string morse [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                        "..-", "...-", ".--", "-..-", "-.--", "--..",
                        "-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----."};

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  run_t exp_q[$];
  run_t mon_e;
  bit   mon_en = 0;
  bit   skip_low = 1;
  bit   prev_key = 0;
  int   run_len = 0;
  int   last_fall = 0;
  int   err_seen = 0;
  int   err_exp = 0;
  int   pending = 0;
  bit   have_mark = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_run(input bit lvl, input int len);
    run_t r;
    r.lvl = lvl;
    r.len = len;
    exp_q.push_back(r);
  endtask

  // Monitor: measures every completed key_out run and pops its expectation.
  initial forever begin
    @(negedge clk);
    if (rst || !mon_en) begin
      prev_key = key_out;
      run_len  = 0;
    end else begin
      if (key_out !== prev_key) begin
        if (prev_key || !skip_low) begin
          if (exp_q.size() == 0) begin
            check("unexpected_run", run_len, 0);
          end else begin
            mon_e = exp_q.pop_front();
            check("run_level", prev_key, mon_e.lvl);
            check(prev_key ? "mark_len" : "space_len", run_len, mon_e.len);
          end
        end else begin
          skip_low = 0;
        end
        if (!key_out) last_fall = cyc;
        prev_key = key_out;
        run_len  = 1;
      end else begin
        run_len++;
      end
      check("busy_vs_ready", busy, !char_ready);
      if (err) begin
        err_seen++;
        check("err_key_low", key_out, 0);
      end
    end
  end

  task automatic begin_stream();
    skip_low  = 1;
    have_mark = 0;
    pending   = 0;
    err_exp   = 0;
    err_seen  = 0;
    mon_en    = 1;
  endtask

  // Enter and leave at a falling edge; char_in is garbage until the handshake edge.
  task automatic send(input int code);
    int  n = 0;
    byte c;
    if (code < 36) begin
      if (have_mark) push_run(0, pending + 1);
      for (int i = 0; i < morse[code].len(); i++) begin
        c = morse[code][i];
        push_run(1, (c == "-") ? 3 * D : D);
        if (i < morse[code].len() - 1) push_run(0, D);
      end
      pending   = 3 * D;
      have_mark = 1;
    end else if (code == 36) begin
      pending += 4 * D;
    end else begin
      pending += 1;
      err_exp++;
    end
    char_valid = 1'b1;
    while (!char_ready && n < 1000) begin
      char_in = 6'($urandom_range(0, 63));
      @(negedge clk);
      n++;
    end
    check("handshake_timeout", char_ready, 1);
    char_in = 6'(code);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic end_stream();
    int n = 0;
    char_valid = 1'b0;
    while (!char_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", char_ready, 1);
    if (have_mark) check("trailing_gap", cyc - last_fall, pending);
    repeat (2) @(negedge clk);
    check("runs_left", exp_q.size(), 0);
    check("err_count", err_seen, err_exp);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int r;
    int code;
    int hi;

    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", {key_out, busy, err, char_ready}, 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", char_ready, 1);
    check("busy_after_reset", busy, 0);
    @(negedge clk);

    begin_stream(); send(4); end_stream();
    begin_stream(); send(0); end_stream();
    begin_stream(); send(4); send(4); end_stream();
    begin_stream(); send(4); send(36); send(4); end_stream();
    begin_stream(); send(40); end_stream();
    begin_stream(); send(4); send(40); send(63); send(4); end_stream();

    for (int s = 0; s < 4; s++) begin
      begin_stream();
      for (int i = 0; i < 6; i++) begin
        r = $urandom_range(0, 9);
        if (r < 7) code = $urandom_range(0, 35);
        else if (r < 8) code = 36;
        else code = $urandom_range(37, 63);
        send(code);
      end
      end_stream();
    end

    mon_en = 0;
    check("rst_pre_ready", char_ready, 1);
    char_in = 6'd19;
    char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    char_valid = 1'b0;
    char_in = 6'($urandom_range(0, 63));
    repeat (14) @(negedge clk);
    check("t_mark_before_rst", key_out, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_abort_key", key_out, 0);
    check("rst_abort_flags", {busy, err, char_ready}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_abort", char_ready, 1);
    hi = 0;
    repeat (120) begin
      @(negedge clk);
      if (key_out) hi++;
    end
    check("no_residual_marks", hi, 0);

`ifdef MORSE_TX_SIDETONE_EN
    char_in = 6'd19;
    char_valid = 1'b1;
    @(posedge clk);
    char_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      check("tone_out", tone_out, (k < 3 * D) ? ((k / 5) % 2) : 0);
    end
    repeat (10) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 The block SHALL have parameter DOT_CYCLES, default 10, giving clock cycles per Morse time unit (legal range 2..65535).
REQ-002 The block SHALL have parameter TONE_DIV, default 50, giving the half-period of the sidetone in clock cycles (used only under REQ-030).
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the reset, synchronous and active-high.
REQ-005 Port char_in  input  6  is the character code: 0..25 = A..Z, 26..35 = digits 0..9, 36 = word space, 37..63 = invalid.
REQ-006 Port char_valid  input  1  indicates that char_in holds a character to send.
REQ-007 Port char_ready  output  1  indicates that the block accepts a character this cycle.
REQ-008 Port key_out  output  1  is the keyed line: 1 = mark (tone on), 0 = space.
REQ-009 Port busy  output  1  is high whenever the FSM is outside IDLE.
REQ-010 Port err  output  1  is a one-cycle pulse when an invalid code is accepted.

Function
REQ-011 A handshake SHALL occur on a rising edge where char_valid=1 and char_ready=1; char_ready SHALL be 1 only in IDLE.
REQ-012 The FSM states SHALL be IDLE, MARK, ELEM_GAP, CHAR_GAP and WORD_GAP; all outputs SHALL be registered.
REQ-013 On a handshake with a letter or digit, the block SHALL latch that code's element pattern (1..5 elements, MSB first, 1 = dash, 0 = dot) and enter MARK, with key_out=1 from the next cycle.
REQ-014 MARK SHALL hold key_out=1 for exactly 1*DOT_CYCLES cycles for a dot and 3*DOT_CYCLES cycles for a dash.
REQ-015 After a non-final element, ELEM_GAP SHALL hold key_out=0 for exactly 1*DOT_CYCLES cycles and then return to MARK for the next element.
REQ-016 After the final element, CHAR_GAP SHALL hold key_out=0 for exactly 3*DOT_CYCLES cycles; the FSM SHALL then enter IDLE with char_ready=1 on the following cycle.
REQ-017 On a handshake with code 36, the FSM SHALL enter WORD_GAP and hold key_out=0 for 4*DOT_CYCLES cycles (4 units, which with the preceding 3-unit character gap makes 7 units) before returning to IDLE.
REQ-018 On a handshake with codes 37..63, the block SHALL pulse err=1 for the next cycle, keep key_out=0, and remain in IDLE.
REQ-019 With char_valid held high continuously, the low time between the last mark of one character and the first mark of the next SHALL be exactly 3*DOT_CYCLES+1 cycles, the extra cycle being the handshake.
REQ-020 char_in SHALL be ignored outside the handshake cycle; changes to it during transmission SHALL have no effect.
REQ-021 The unit counter SHALL be sized to hold 4*DOT_CYCLES-1 and SHALL never wrap within a state.

Reset
REQ-022 While rst=1, the block SHALL drive key_out=0, busy=0, err=0 and char_ready=0, and the FSM SHALL be in IDLE with all counters cleared.
REQ-023 In the first cycle after rst deasserts, char_ready SHALL be 1.
REQ-024 An rst asserted mid-character SHALL abort transmission: key_out=0 after the same edge, and no residual elements are sent after release.

Configuration
REQ-025 Macro MORSE_TX_SIDETONE_EN SHALL control the sidetone feature.
REQ-026 When MORSE_TX_SIDETONE_EN is defined, output port tone_out (1 bit) SHALL exist; it SHALL toggle every TONE_DIV cycles while key_out=1, be 0 while key_out=0, and be 0 in reset.
REQ-027 When MORSE_TX_SIDETONE_EN is undefined, tone_out and its divider SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package morse_pkg SHALL hold the character-code constants (CODE_SPACE=36, CODE_MAX_VALID=36), the unit constants (DOT=1, DASH=3, ELEM_GAP=1, CHAR_GAP=3, WORD_EXTRA=4) and the FSM state enum.
REQ-029 Sub-module morse_rom SHALL be purely combinational: char_in -> {valid, len[2:0], pattern[4:0]}, covering A..Z and 0..9 in International Morse.
REQ-030 morse_tx SHALL contain the FSM, the unit counter, the element index and the optional sidetone divider.

Verification (DOT_CYCLES=10)
REQ-031 Send 'E' (code 4) -> key_out high for 10 cycles, then low for 30 cycles, then char_ready=1.
REQ-032 Send 'A' (code 0) -> key_out high 10, low 10, high 30, low 30 cycles; busy=1 throughout.
REQ-033 Send 'E','E' with char_valid held high -> exactly 31 low cycles between the two marks.
REQ-034 Send 'E', space (36), 'E' back-to-back -> 71 low cycles between the marks; send code 40 -> err pulses one cycle and key_out stays 0.
REQ-035 Assert rst during the dash of 'T' (code 19) -> key_out=0 on the next edge; char_ready=1 in the first cycle after release; no further marks.
REQ-036 With MORSE_TX_SIDETONE_EN and TONE_DIV=5, send 'T' -> tone_out toggles every 5 cycles during the 30-cycle mark and is 0 otherwise.
